// File: rtl/reg_file_sb.sv
// Parametrised register file with two combinational read ports, one write port,
// optional write-to-read bypass and a reserve/release busy-bit scoreboard.
module reg_file_sb #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      DEPTH     = 8,
    parameter int unsigned      BYPASS    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     AW        = $clog2(DEPTH),
    localparam int unsigned     CW        = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Clear,
    input  logic             WE,
    input  logic [AW-1:0]    WAddr,
    input  logic [WIDTH-1:0] WData,
    input  logic [AW-1:0]    RAddr1,
    input  logic [AW-1:0]    RAddr2,
    output logic [WIDTH-1:0] RData1,
    output logic [WIDTH-1:0] RData2,
    output logic             Busy1,
    output logic             Busy2,
    input  logic             Rsv,
    input  logic [AW-1:0]    RsvAddr,
    output logic             RsvStall,
    output logic [CW-1:0]    BusyCount
);

    localparam int unsigned    NSLOT = 2 ** AW;
    // One bit per encodable address: set where the address maps to a real register.
    localparam logic [NSLOT-1:0] VALID = {NSLOT{1'b1}} >> (NSLOT - DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;

    logic wr_ok;
    logic rsv_in;
    logic rsv_ok;
    logic rel;
    logic [CW-1:0] count_next;

    // Scoreboard decisions for this cycle.
    always_comb begin
        wr_ok      = WE && VALID[WAddr];
        rsv_in     = Rsv && VALID[RsvAddr];
        rel        = wr_ok && busy[WAddr];
        RsvStall   = rsv_in && busy[RsvAddr] && !(wr_ok && (WAddr == RsvAddr));
        rsv_ok     = rsv_in && !RsvStall;
        count_next = BusyCount + CW'(rsv_ok) - CW'(rel);
    end

    // Storage, busy bits and running busy count; Clear beats write and reserve.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) regs[i] <= RESET_VAL;
            busy      <= '0;
            BusyCount <= '0;
        end else if (Clear) begin
            for (int i = 0; i < int'(DEPTH); i++) regs[i] <= RESET_VAL;
            busy      <= '0;
            BusyCount <= '0;
        end else begin
            if (wr_ok) begin
                regs[WAddr] <= WData;
                busy[WAddr] <= 1'b0;
            end
            // Placed after the release so a same-register release+reserve ends busy.
            if (rsv_ok) busy[RsvAddr] <= 1'b1;
            BusyCount <= count_next;
        end
    end

    // Read port 1.
    always_comb begin
        RData1 = '0;
        Busy1  = 1'b0;
        if (VALID[RAddr1]) begin
            if ((BYPASS != 0) && wr_ok && (WAddr == RAddr1)) begin
                RData1 = WData;
            end else begin
                RData1 = regs[RAddr1];
                Busy1  = busy[RAddr1];
            end
        end
    end

    // Read port 2.
    always_comb begin
        RData2 = '0;
        Busy2  = 1'b0;
        if (VALID[RAddr2]) begin
            if ((BYPASS != 0) && wr_ok && (WAddr == RAddr2)) begin
                RData2 = WData;
            end else begin
                RData2 = regs[RAddr2];
                Busy2  = busy[RAddr2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: default, no-bypass and 6x32 instances.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr1;
    logic [2:0]  raddr2;
    logic        rsv;
    logic [2:0]  rsv_addr;

    logic        c_we;
    logic [2:0]  c_waddr;
    logic [31:0] c_wdata;
    logic [2:0]  c_raddr1;
    logic [2:0]  c_raddr2;
    logic        c_rsv;
    logic [2:0]  c_rsv_addr;

    logic [15:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
    logic        a_busy1, a_busy2, a_stall, b_busy1, b_busy2, b_stall;
    logic [3:0]  a_count, b_count;
    logic [31:0] c_rdata1, c_rdata2;
    logic        c_busy1, c_busy2, c_stall;
    logic [2:0]  c_count;

    always #5 clk = ~clk;

    reg_file_sb dut_a (
        .Clk(clk), .Reset_n(rst_n), .Clear(clear), .WE(we), .WAddr(waddr), .WData(wdata),
        .RAddr1(raddr1), .RAddr2(raddr2), .RData1(a_rdata1), .RData2(a_rdata2),
        .Busy1(a_busy1), .Busy2(a_busy2), .Rsv(rsv), .RsvAddr(rsv_addr),
        .RsvStall(a_stall), .BusyCount(a_count)
    );

    reg_file_sb #(.BYPASS(0)) dut_b (
        .Clk(clk), .Reset_n(rst_n), .Clear(clear), .WE(we), .WAddr(waddr), .WData(wdata),
        .RAddr1(raddr1), .RAddr2(raddr2), .RData1(b_rdata1), .RData2(b_rdata2),
        .Busy1(b_busy1), .Busy2(b_busy2), .Rsv(rsv), .RsvAddr(rsv_addr),
        .RsvStall(b_stall), .BusyCount(b_count)
    );

    reg_file_sb #(.DEPTH(6), .WIDTH(32)) dut_c (
        .Clk(clk), .Reset_n(rst_n), .Clear(clear), .WE(c_we), .WAddr(c_waddr), .WData(c_wdata),
        .RAddr1(c_raddr1), .RAddr2(c_raddr2), .RData1(c_rdata1), .RData2(c_rdata2),
        .Busy1(c_busy1), .Busy2(c_busy2), .Rsv(c_rsv), .RsvAddr(c_rsv_addr),
        .RsvStall(c_stall), .BusyCount(c_count)
    );

    typedef enum int {
        A_RD1, A_RD2, A_BUSY1, A_BUSY2, A_STALL, A_COUNT,
        B_RD2, C_RD1, C_RD2, C_BUSY1, C_STALL, C_COUNT
    } sig_e;

    typedef struct {
        string       name;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic expect_val(input string name, input sig_e sig, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are stable mid-cycle, so drain and compare on every falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.sig)
                A_RD1:   act = 32'(a_rdata1);
                A_RD2:   act = 32'(a_rdata2);
                A_BUSY1: act = 32'(a_busy1);
                A_BUSY2: act = 32'(a_busy2);
                A_STALL: act = 32'(a_stall);
                A_COUNT: act = 32'(a_count);
                B_RD2:   act = 32'(b_rdata2);
                C_RD1:   act = c_rdata1;
                C_RD2:   act = c_rdata2;
                C_BUSY1: act = 32'(c_busy1);
                C_STALL: act = 32'(c_stall);
                default: act = 32'(c_count);
            endcase
            n_checks++;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", e.name, act, e.exp, $time);
        end
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = 3'd0; raddr2 = 3'd7; rsv = 1'b0; rsv_addr = '0;
        c_we = 1'b0; c_waddr = '0; c_wdata = '0; c_raddr1 = '0; c_raddr2 = '0;
        c_rsv = 1'b0; c_rsv_addr = '0;

        step();
        expect_val("reset_rd1", A_RD1, 32'h0);
        expect_val("reset_rd2", A_RD2, 32'h0);
        expect_val("reset_busy1", A_BUSY1, 32'h0);
        expect_val("reset_busy2", A_BUSY2, 32'h0);
        expect_val("reset_stall", A_STALL, 32'h0);
        expect_val("reset_count", A_COUNT, 32'h0);

        step();
        rst_n = 1'b1;
        we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF;
        step();
        we = 1'b0; raddr1 = 3'd3;
        expect_val("write_r3", A_RD1, 32'hBEEF);

        // Same-cycle write forwarding versus no-bypass instance.
        step();
        we = 1'b1; waddr = 3'd5; wdata = 16'h1234; raddr2 = 3'd5;
        expect_val("bypass_rd2", A_RD2, 32'h1234);
        expect_val("bypass_busy2", A_BUSY2, 32'h0);
        expect_val("nobypass_old", B_RD2, 32'h0);
        step();
        we = 1'b0;
        expect_val("after_wr_rd2", A_RD2, 32'h1234);
        expect_val("nobypass_new", B_RD2, 32'h1234);

        // Reserve, stall on double reserve, release by write.
        step();
        rsv = 1'b1; rsv_addr = 3'd2; raddr1 = 3'd2;
        expect_val("rsv_not_yet_busy", A_BUSY1, 32'h0);
        expect_val("rsv_no_stall", A_STALL, 32'h0);
        step();
        expect_val("rsv_busy1", A_BUSY1, 32'h1);
        expect_val("rsv_count1", A_COUNT, 32'h1);
        expect_val("rsv_again_stall", A_STALL, 32'h1);
        step();
        rsv = 1'b0; we = 1'b1; waddr = 3'd2; wdata = 16'h00AA;
        expect_val("stall_count_held", A_COUNT, 32'h1);
        expect_val("release_bypass_busy", A_BUSY1, 32'h0);
        expect_val("release_bypass_data", A_RD1, 32'h00AA);
        step();
        we = 1'b0;
        expect_val("released_busy1", A_BUSY1, 32'h0);
        expect_val("released_count", A_COUNT, 32'h0);
        expect_val("released_data", A_RD1, 32'h00AA);

        // Release plus re-reserve of the same register.
        step();
        rsv = 1'b1; rsv_addr = 3'd4;
        step();
        we = 1'b1; waddr = 3'd4; wdata = 16'h4444; raddr1 = 3'd4;
        expect_val("rerelease_no_stall", A_STALL, 32'h0);
        expect_val("rerelease_count_pre", A_COUNT, 32'h1);
        step();
        we = 1'b0; rsv = 1'b0;
        expect_val("rerelease_busy", A_BUSY1, 32'h1);
        expect_val("rerelease_count", A_COUNT, 32'h1);
        expect_val("rerelease_data", A_RD1, 32'h4444);

        // Release r1 while reserving r6.
        step();
        rsv = 1'b1; rsv_addr = 3'd1;
        step();
        rsv_addr = 3'd6; we = 1'b1; waddr = 3'd1; wdata = 16'h0011;
        raddr1 = 3'd1; raddr2 = 3'd6;
        expect_val("swap_count_pre", A_COUNT, 32'h2);
        expect_val("swap_busy2_current", A_BUSY2, 32'h0);
        step();
        we = 1'b0; rsv = 1'b0;
        expect_val("swap_count", A_COUNT, 32'h2);
        expect_val("swap_busy_r1", A_BUSY1, 32'h0);
        expect_val("swap_busy_r6", A_BUSY2, 32'h1);
        expect_val("swap_data_r1", A_RD1, 32'h0011);

        // Fill the scoreboard (r4 and r6 already busy).
        for (int i = 0; i < 8; i++) begin
            if (i != 4 && i != 6) begin
                step();
                rsv = 1'b1; rsv_addr = 3'(i);
            end
        end
        step();
        rsv = 1'b0;
        expect_val("full_count", A_COUNT, 32'h8);

        // Clear wins over a same-cycle write.
        step();
        clear = 1'b1; we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF;
        step();
        clear = 1'b0; we = 1'b0; raddr1 = 3'd0; raddr2 = 3'd5;
        expect_val("clear_r0_not_written", A_RD1, 32'h0);
        expect_val("clear_r5", A_RD2, 32'h0);
        expect_val("clear_count", A_COUNT, 32'h0);
        expect_val("clear_busy1", A_BUSY1, 32'h0);

        // Non-power-of-two depth: out-of-range write, read and reserve.
        c_we = 1'b1; c_waddr = 3'd2; c_wdata = 32'hCAFEF00D;
        step();
        c_waddr = 3'd7; c_wdata = 32'hDEADBEEF; c_raddr1 = 3'd7; c_raddr2 = 3'd2;
        c_rsv = 1'b1; c_rsv_addr = 3'd7;
        expect_val("c_oor_read7", C_RD1, 32'h0);
        expect_val("c_oor_busy7", C_BUSY1, 32'h0);
        expect_val("c_oor_rsv_stall", C_STALL, 32'h0);
        step();
        c_we = 1'b0; c_rsv = 1'b0; c_raddr1 = 3'd6;
        expect_val("c_r2_kept", C_RD2, 32'hCAFEF00D);
        expect_val("c_oor_read6", C_RD1, 32'h0);
        expect_val("c_oor_rsv_count", C_COUNT, 32'h0);

        // Asynchronous reset between edges.
        step();
        we = 1'b1; waddr = 3'd4; wdata = 16'h5555; rsv = 1'b1; rsv_addr = 3'd3;
        step();
        we = 1'b0; rsv = 1'b0; raddr1 = 3'd4;
        #1;
        rst_n = 1'b0;
        expect_val("async_rd1", A_RD1, 32'h0);
        expect_val("async_count", A_COUNT, 32'h0);
        expect_val("async_c_rd2", C_RD2, 32'h0);
        step();
        rst_n = 1'b1;

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks += q.size();
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
            q.delete();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised general-purpose register file with an integrated busy-bit scoreboard. Successor to the fixed 8x16 LC-3 register file.
- Provides WIDTH x DEPTH storage, one write port, two independent read ports (both address-driven, no IR slicing), optional write-to-read bypass.
- A reserve/release scoreboard marks destinations with in-flight results, so a multi-cycle datapath can stall on RAW hazards.
- Sits between the datapath bus and the ALU/SR muxes.

Parameters:
WIDTH, 16, data bits per register
DEPTH, 8, number of registers (>=2; need not be a power of two)
AW, $clog2(DEPTH), address width (derived, not overridden)
BYPASS, 1, 1 = a same-cycle write is forwarded to read ports; 0 = reads show pre-write contents
RESET_VAL, 0, value loaded into every register on reset/Clear

Ports:
Clk  in  1  rising-edge clock
Reset_n  in  1  asynchronous active-low reset
Clear  in  1  synchronous clear of registers and scoreboard
WE  in  1  write enable
WAddr  in  AW  write address
WData  in  WIDTH  write data
RAddr1  in  AW  read port 1 address
RAddr2  in  AW  read port 2 address
RData1  out  WIDTH  read port 1 data
RData2  out  WIDTH  read port 2 data
Busy1  out  1  register at RAddr1 has a pending result
Busy2  out  1  register at RAddr2 has a pending result
Rsv  in  1  reserve request: mark RsvAddr busy
RsvAddr  in  AW  register to reserve
RsvStall  out  1  reserve request rejected this cycle
BusyCount  out  $clog2(DEPTH+1)  number of busy registers

Behaviour:
- Reset_n low (async): all registers = RESET_VAL, all busy bits = 0, BusyCount = 0. Combinational outputs follow from that state: RData* = RESET_VAL (addr < DEPTH), Busy* = 0, RsvStall = 0.
- Clear is synchronous and has priority over WE and Rsv in the same cycle. Effect is the same as reset, one edge later.
- Write: on posedge with WE=1 and WAddr < DEPTH, reg[WAddr] <= WData and busy[WAddr] <= 0 (release).
  - Writing a non-busy register is legal; busy stays 0.
- Read: combinational, zero latency.
  - RDatan = reg[RAddrn] and Busyn = busy[RAddrn].
  - If BYPASS=1, WE=1 and WAddr == RAddrn: RDatan = WData and Busyn = 0. When the condition holds, Rsv is 0 or RsvAddr != RAddrn; the cases where Rsv targets RAddrn are defined below.
  - If BYPASS=0: RDatan shows the old value; Busyn is still computed from the current busy bits (no bypass).
- Reserve, with RsvAddr < DEPTH:
  - If busy[RsvAddr] = 0: set the bit on the next edge; RsvStall = 0.
  - If busy[RsvAddr] = 1 and no same-cycle write releases it: RsvStall = 1 (combinational), no state change.
  - Same-cycle WE with WAddr == RsvAddr and the bit busy: release and re-reserve, final busy = 1, RsvStall = 0. Data is still written.
  - Reserve of an address already being reserved is impossible; there is only one Rsv port.
- Busy1/Busy2 when Rsv targets RAddrn in the same cycle: Busyn reflects the current state only. The reservation becomes visible the next cycle.
- BusyCount is registered, equal to the popcount of busy bits after each edge. It is updated incrementally:
  - +1 for an accepted reserve of a non-busy register.
  - -1 for a release of a busy register.
  - Net 0 for release plus re-reserve of the same register.
  - Release of one register plus reserve of another: net 0.
  - Never exceeds DEPTH; never underflows.
- Out-of-range addresses (>= DEPTH, only possible when DEPTH is not a power of two):
  - Writes: ignored, no release.
  - Reads: RData = 0, Busy = 0.
  - Reserve: ignored, RsvStall = 0.
- Reset_n asserted mid-operation: immediate return to reset state. Requests in flight are lost; Rsv and WE in that cycle have no effect.

Test Plan:
- Reset, then RAddr1=0, RAddr2=7 -> RData1=RData2=0x0000, Busy1=Busy2=0, BusyCount=0. Then write 0xBEEF to r3; next cycle RAddr1=3 -> 0xBEEF.
- BYPASS=1: WE=1, WAddr=5, WData=0x1234, RAddr2=5 in the same cycle -> RData2=0x1234 before the edge. With BYPASS=0, the same stimulus gives the old value 0x0000.
- Rsv r2 -> next cycle Busy1=1 (RAddr1=2), BusyCount=1. Rsv r2 again -> RsvStall=1, BusyCount stays 1. Write r2=0x00AA -> Busy1=0, BusyCount=0, RData1=0x00AA.
- Same-cycle WE to r4 (busy) with Rsv r4 -> RsvStall=0, r4 updated, busy[r4]=1, BusyCount unchanged. Same-cycle release r1 plus reserve r6 -> BusyCount unchanged, busy[r1]=0, busy[r6]=1.
- Reserve all 8 registers -> BusyCount=8. Clear asserted together with WE=1 to r0 -> all registers 0, BusyCount=0, r0 not written.
- DEPTH=6, WIDTH=32: write to addr 7 -> no change; read addr 6 -> 0. Assert Reset_n low between clock edges -> outputs return to RESET_VAL immediately, without waiting for an edge.
